// File: rtl/mux_select_sequencer_pkg.sv
// Shared types and defaults for the mux select sequencer.
// Holds the FSM state encoding and the default timing constants.
package mux_select_sequencer_pkg;

    typedef enum logic [1:0] {
        MANUAL = 2'b00,
        AUTO   = 2'b01,
        FROZEN = 2'b10
    } seq_state_t;

    localparam int DEF_DEB_CYCLES = 1000000;
    localparam int DEF_SCAN_DIV   = 50000000;

endpackage

// File: rtl/mux_select_sequencer_debounce_sync.sv
// Two-flop synchronizer followed by a stability-counting debouncer.
// dout follows din only after din held a new level for DEB_CYCLES clocks.
module debounce_sync
    import mux_select_sequencer_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int CW = $clog2(DEB_CYCLES);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
        end
    end

    // Any sample matching the accepted level restarts the stability window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= 1'b0;
            cnt    <= '0;
        end else if (sync2 == stable) begin
            cnt <= '0;
        end else if (cnt == CW'(DEB_CYCLES - 1)) begin
            stable <= sync2;
            cnt    <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign dout = stable;

endmodule

// File: rtl/mux_select_sequencer.sv
// Select-bus generator for mux2x1 trees: manual step or auto scan.
// Debounced board inputs drive a MANUAL/AUTO/FROZEN sequencer.
module mux_select_sequencer
    import mux_select_sequencer_pkg::*;
#(
    parameter int SEL_W      = 3,
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int SCAN_DIV   = DEF_SCAN_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             btn_step,
    input  logic             mode_auto,
    input  logic             hold,
    output logic [SEL_W-1:0] sel,
    output logic             sel_change,
    output logic             btn_db
);

    localparam int PW = $clog2(SCAN_DIV);

    logic          mode_db;
    logic          hold_db;
    logic          btn_prev;
    logic          step_q;
    logic [PW-1:0] pres;
    logic          tick;
    logic          advance;

    seq_state_t state;
    seq_state_t state_nxt;

    debounce_sync #(.DEB_CYCLES(DEB_CYCLES)) u_btn (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (btn_step),
        .dout  (btn_db)
    );

    debounce_sync #(.DEB_CYCLES(DEB_CYCLES)) u_mode (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (mode_auto),
        .dout  (mode_db)
    );

    debounce_sync #(.DEB_CYCLES(DEB_CYCLES)) u_hold (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (hold),
        .dout  (hold_db)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_prev <= 1'b0;
            step_q   <= 1'b0;
        end else begin
            btn_prev <= btn_db;
            step_q   <= btn_db & ~btn_prev;
        end
    end

    // Held at zero outside AUTO, so each entry starts a full period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pres <= '0;
        end else if (state != AUTO) begin
            pres <= '0;
        end else if (pres == PW'(SCAN_DIV - 1)) begin
            pres <= '0;
        end else begin
            pres <= pres + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MANUAL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            MANUAL: begin
                if (hold_db)      state_nxt = FROZEN;
                else if (mode_db) state_nxt = AUTO;
            end
            AUTO: begin
                if (hold_db)       state_nxt = FROZEN;
                else if (!mode_db) state_nxt = MANUAL;
            end
            FROZEN: begin
                if (!hold_db) state_nxt = mode_db ? AUTO : MANUAL;
            end
            default: state_nxt = MANUAL;
        endcase
    end

    // A step or tick that coincides with a state exit is dropped.
    always_comb begin
        tick    = (state == AUTO) && (pres == PW'(SCAN_DIV - 1));
        advance = 1'b0;
        unique case (state)
            MANUAL:  advance = !hold_db && !mode_db && step_q;
            AUTO:    advance = !hold_db && mode_db && tick;
            default: advance = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel        <= '0;
            sel_change <= 1'b0;
        end else begin
            sel_change <= advance;
            if (advance) sel <= sel + SEL_W'(1);
        end
    end

endmodule

// File: tb/tb_mux_select_sequencer.sv
// Randomized scoreboard bench for mux_select_sequencer.
// A behavioural model predicts each select update and debounced level.
module tb_mux_select_sequencer;

    localparam int SEL_W = 3;
    localparam int DEB   = 4;
    localparam int SCAN  = 8;
    localparam int NSEL  = 1 << SEL_W;

    logic             clk;
    logic             rst_n;
    logic             btn_step;
    logic             mode_auto;
    logic             hold;
    logic [SEL_W-1:0] sel;
    logic             sel_change;
    logic             btn_db;

    int checks = 0;
    int errors = 0;

    mux_select_sequencer #(
        .SEL_W      (SEL_W),
        .DEB_CYCLES (DEB),
        .SCAN_DIV   (SCAN)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_step   (btn_step),
        .mode_auto  (mode_auto),
        .hold       (hold),
        .sel        (sel),
        .sel_change (sel_change),
        .btn_db     (btn_db)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int cyc;
        int val;
    } exp_t;

    exp_t sb[$];

    // Model: index 0 = button, 1 = mode, 2 = hold.
    int cyc = 0;
    int sel_m;
    int mst;
    int entry;
    int rise;
    bit db[3];
    int run[3];
    bit raw1[3];
    bit raw2[3];

    task automatic model_reset();
        sel_m = 0;
        mst   = 0;
        entry = -1000;
        rise  = -1000;
        for (int i = 0; i < 3; i++) begin
            db[i]   = 1'b0;
            run[i]  = 0;
            raw1[i] = 1'b0;
            raw2[i] = 1'b0;
        end
        sb.delete();
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            bit adv;
            bit h;
            bit m;
            bit now[3];
            int nst;
            cyc++;
            h   = db[2];
            m   = db[1];
            adv = 1'b0;
            // Auto steps land every SCAN cycles after entering auto.
            if (mst == 1 && !h && m && ((cyc - entry) % SCAN) == 0)
                adv = 1'b1;
            // Manual step lands two cycles after the debounced rise.
            if (mst == 0 && !h && !m && rise == cyc - 2)
                adv = 1'b1;
            nst = h ? 2 : (m ? 1 : 0);
            if (nst == 1 && mst != 1) entry = cyc;
            mst = nst;
            now[0] = btn_step;
            now[1] = mode_auto;
            now[2] = hold;
            for (int i = 0; i < 3; i++) begin
                if (raw2[i] != db[i]) begin
                    run[i]++;
                    if (run[i] == DEB) begin
                        db[i]  = raw2[i];
                        run[i] = 0;
                        if (i == 0 && db[0]) rise = cyc;
                    end
                end else begin
                    run[i] = 0;
                end
                raw2[i] = raw1[i];
                raw1[i] = now[i];
            end
            if (adv) begin
                exp_t e;
                sel_m = (sel_m + 1) % NSEL;
                e.cyc = cyc;
                e.val = sel_m;
                sb.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            if (btn_db !== db[0]) begin
                errors++;
                $display("FAIL btn_db cyc=%0d actual=%b required=%b",
                         cyc, btn_db, db[0]);
            end
            checks++;
            if (sel !== SEL_W'(sel_m)) begin
                errors++;
                $display("FAIL sel_level cyc=%0d actual=%0d required=%0d",
                         cyc, sel, sel_m);
            end
            if (sel_change) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change cyc=%0d actual=1 required=0",
                             cyc);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (e.cyc != cyc || sel !== SEL_W'(e.val)) begin
                        errors++;
                        $display("FAIL step cyc=%0d actual=%0d@%0d required=%0d@%0d",
                                 cyc, sel, cyc, e.val, e.cyc);
                    end
                end
            end else if (sb.size() > 0 && sb[0].cyc <= cyc) begin
                checks++;
                errors++;
                $display("FAIL missed_change cyc=%0d actual=0 required=1 (sel=%0d)",
                         cyc, sb[0].val);
                void'(sb.pop_front());
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int hi, input int lo);
        btn_step = 1'b1;
        wait_cyc(hi);
        btn_step = 1'b0;
        wait_cyc(lo);
    endtask

    task automatic do_reset(input bit check_now);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        if (check_now) begin
            checks++;
            if (sel !== '0 || sel_change !== 1'b0 || btn_db !== 1'b0) begin
                errors++;
                $display("FAIL async_reset actual=%0d/%b/%b required=0/0/0",
                         sel, sel_change, btn_db);
            end
        end
        wait_cyc(3);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        btn_step  = 1'b0;
        mode_auto = 1'b0;
        hold      = 1'b0;
        wait_cyc(3);
        checks++;
        if (sel !== '0 || sel_change !== 1'b0 || btn_db !== 1'b0) begin
            errors++;
            $display("FAIL reset_state actual=%0d/%b/%b required=0/0/0",
                     sel, sel_change, btn_db);
        end
        #2;
        rst_n = 1'b1;
        wait_cyc(5);

        press(20, 20);

        for (int i = 0; i < 15; i++) begin
            btn_step = ~btn_step;
            wait_cyc(2);
        end
        btn_step = 1'b1;
        wait_cyc(20);
        btn_step = 1'b0;
        wait_cyc(20);

        press(3, 20);

        do_reset(1'b0);
        wait_cyc(5);
        for (int i = 0; i < NSEL; i++) press(10, 10);

        mode_auto = 1'b1;
        wait_cyc(30);
        press(10, 10);
        press(12, 38);
        mode_auto = 1'b0;
        wait_cyc(20);

        mode_auto = 1'b1;
        wait_cyc(30);
        hold = 1'b1;
        wait_cyc(10);
        press(10, 20);
        hold = 1'b0;
        wait_cyc(40);
        mode_auto = 1'b0;
        wait_cyc(20);

        for (int i = 0; i < 60; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 6)      btn_step  = ~btn_step;
            else if (r < 8) mode_auto = ~mode_auto;
            else            hold      = ~hold;
            wait_cyc($urandom_range(1, 14));
        end
        btn_step  = 1'b0;
        mode_auto = 1'b0;
        hold      = 1'b0;
        wait_cyc(20);

        do_reset(1'b0);
        wait_cyc(5);
        for (int i = 0; i < 5; i++) press(10, 10);
        do_reset(1'b1);
        wait_cyc(20);

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pending_at_end actual=%0d required=0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
